// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// state encoding, opcode constants, instruction-type codes and the
// bit positions inside the 8-bit datapath control word.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // T_NONE doubles as the reset value and the "illegal opcode" marker
  typedef enum logic [2:0] {
    T_NONE  = 3'd0,
    T_LOAD  = 3'd1,
    T_STORE = 3'd2,
    T_RIMM  = 3'd3,
    T_R     = 3'd4,
    T_B     = 3'd5
  } itype_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RIMM  = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  localparam int CW_PC_WE     = 7;
  localparam int CW_IR_WE     = 6;
  localparam int CW_INC_IMM   = 5;
  localparam int CW_REG_IMM   = 4;
  localparam int CW_ALU_DMEM  = 3;
  localparam int CW_W_REG     = 2;
  localparam int CW_R_DMEM    = 1;
  localparam int CW_W_DMEM    = 0;

  function automatic itype_t decode_opcode(input logic [6:0] op);
    case (op)
      OP_LOAD:  return T_LOAD;
      OP_STORE: return T_STORE;
      OP_RIMM:  return T_RIMM;
      OP_R:     return T_R;
      OP_B:     return T_B;
      default:  return T_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction/data memory request-acknowledge bundle. The sequencer is the
// master (drives the requests), the memory side is the slave (drives acks).
interface multicycle_ctrl_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, input imem_ack, input dmem_ack);
  modport slave  (input imem_req, input dmem_req, output imem_ack, output dmem_ack);
endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// Counts un-acknowledged wait cycles in FETCH/MEM. 'expired' is high while
// the current cycle is the last one in which an ack may still be accepted.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // wait-cycle counter: cleared outside wait states, advances per missed ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, bus-timeout FAULT and performance counters.
// Optional feature macro: CTRL_TRAP_EN (illegal opcode -> one-cycle TRAP
// state with trap pulse; otherwise illegal opcodes retire as NOPs).
// rst_n is expected to be released synchronously to clk by the reset tree.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int PERF_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           instr_opcode,
  input  logic                 branch_taken,
  multicycle_ctrl_fsm_if.master bus,
  output logic [7:0]           ctrl_wrd,
  output logic                 fault,
  output logic                 trap,
  output logic [PERF_W-1:0]    cycle_cnt,
  output logic [PERF_W-1:0]    instret_cnt
);

`ifdef CTRL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = S_WB;
`endif

  state_t state, next_state;
  itype_t itype;
  logic   taken;
  logic   imem_req, dmem_req;
  logic   timer_clear, timer_tick, timer_expired;

  ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // state register plus the instruction type and branch outcome latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      itype <= T_NONE;
      taken <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) itype <= decode_opcode(instr_opcode);
      if (state == S_EXEC)   taken <= (itype == T_B) && branch_taken;
    end
  end

  // next-state, memory requests, control word and wait-timer control
  always_comb begin
    next_state  = state;
    ctrl_wrd    = '0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    timer_clear = 1'b1;
    timer_tick  = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        imem_req           = 1'b1;
        ctrl_wrd[CW_IR_WE] = bus.imem_ack;
        timer_clear        = 1'b0;
        timer_tick         = !bus.imem_ack;
        if (bus.imem_ack)       next_state = S_DECODE;
        else if (timer_expired) next_state = S_FAULT;
      end
      S_DECODE: begin
        if (decode_opcode(instr_opcode) == T_NONE) next_state = ILLEGAL_NEXT;
        else                                       next_state = S_EXEC;
      end
      S_EXEC: begin
        ctrl_wrd[CW_REG_IMM] = (itype == T_LOAD) || (itype == T_STORE) || (itype == T_RIMM);
        if ((itype == T_LOAD) || (itype == T_STORE)) next_state = S_MEM;
        else                                         next_state = S_WB;
      end
      S_MEM: begin
        dmem_req            = 1'b1;
        ctrl_wrd[CW_R_DMEM] = (itype == T_LOAD);
        ctrl_wrd[CW_W_DMEM] = (itype == T_STORE);
        timer_clear         = 1'b0;
        timer_tick          = !bus.dmem_ack;
        if (bus.dmem_ack)       next_state = S_WB;
        else if (timer_expired) next_state = S_FAULT;
      end
      S_WB: begin
        ctrl_wrd[CW_PC_WE]    = 1'b1;
        ctrl_wrd[CW_INC_IMM]  = taken && (itype == T_B);
        ctrl_wrd[CW_W_REG]    = (itype == T_LOAD) || (itype == T_R) || (itype == T_RIMM);
        ctrl_wrd[CW_ALU_DMEM] = (itype == T_LOAD);
        next_state            = S_FETCH;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        ctrl_wrd[CW_PC_WE] = 1'b1;
        next_state         = S_FETCH;
      end
`endif
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.dmem_req = dmem_req;
  assign fault        = (state == S_FAULT);

`ifdef CTRL_TRAP_EN
  assign trap = (state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

  // free-running cycle counter and retired-instruction counter, both frozen in FAULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_FAULT) cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (state == S_WB)    instret_cnt <= instret_cnt + PERF_W'(1);
    end
  end

endmodule
